// File: rtl/cordic_sched_pkg.sv
// Shared types for the CORDIC channel scheduler: FSM state, default widths, in-flight tag.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DW  = 16;
  localparam int DEF_TW  = 17;
  // Tag channel field is sized for the largest supported channel count (16).
  localparam int MAX_CHW = 4;

  typedef struct packed {
    logic               vld;
    logic [MAX_CHW-1:0] chan;
  } tag_t;

endpackage

// File: rtl/cordic_chan_sched_if.sv
// Bundle of request, engine and result signals around the CORDIC channel scheduler.
// Latency: n/a (wires only).
// Backpressure: per-channel valid/ready on requests; engine and results have none.
// Ports: req_valid/req_ready/req_cx/req_cy (channels), eng_* (shared engine), res_* (results).
//   slave  = scheduler side, master = channels + engine + consumers side.
interface cordic_chan_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int TW  = 17
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*DW-1:0] req_cx;
  logic [NCH*DW-1:0] req_cy;
  logic [DW-1:0]     eng_cx;
  logic [DW-1:0]     eng_cy;
  logic              eng_load;
  logic [TW-1:0]     eng_theta;
  logic [1:0]        eng_quad;
  logic              res_valid;
  logic [CHW-1:0]    res_chan;
  logic [TW-1:0]     res_theta;
  logic [1:0]        res_quad;

  modport slave (
    input  req_valid, req_cx, req_cy, eng_theta, eng_quad,
    output req_ready, eng_cx, eng_cy, eng_load,
           res_valid, res_chan, res_theta, res_quad
  );

  modport master (
    output req_valid, req_cx, req_cy, eng_theta, eng_quad,
    input  req_ready, eng_cx, eng_cy, eng_load,
           res_valid, res_chan, res_theta, res_quad
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; grant is zero when nothing requests.
// Ports: req (requests), ptr (search start), gnt/gnt_idx/gnt_vld (winner), next_ptr (winner+1, or ptr if none).
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           gnt_vld,
  output logic [CHW-1:0] next_ptr
);

  always_comb begin : arb
    int idx;
    idx      = 0;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    next_ptr = ptr;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = CHW'(idx);
        next_ptr     = CHW'((idx + 1) % NCH);
      end
    end
  end

endmodule

// File: rtl/cordic_chan_sched.sv
// Shares one pipelined CORDIC engine among NCH channels; tags each issue and returns theta/quad with its channel id.
// Latency: handshake to eng_load 1 cycle; handshake to res_valid LAT+2 cycles; one issue per cycle.
// Backpressure: per-channel ready is one-hot on the winner, only in RUN with en; results have no backpressure.
// Ports: clk, rst (sync, active-high), en (scheduling enable), busy (work pending), bus (slave modport).
// Build option: CORDIC_SCHED_PRIO_EN gives channel 0 absolute priority; others round-robin over 1..NCH-1.
module cordic_chan_sched
  import cordic_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int LAT = 10,
  parameter int DW  = DEF_DW,
  parameter int TW  = DEF_TW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               busy,
  cordic_chan_sched_if.slave bus
);

  localparam int CHW = $clog2(NCH);

  state_t         state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_next;
  logic [NCH-1:0] arb_req, arb_gnt, gnt;
  logic [CHW-1:0] arb_idx, arb_next, gnt_idx;
  logic           arb_vld, gnt_vld;
  logic           grant_ok, hs, pipe_any;
  logic [NCH-1:0] req_ready;

  logic [DW-1:0]  eng_cx_q, eng_cy_q;
  logic           eng_load_q;
  logic [CHW-1:0] eng_chan_q;
  tag_t           pipe_q [LAT];

  logic           res_valid_q;
  logic [CHW-1:0] res_chan_q;
  logic [TW-1:0]  res_theta_q;
  logic [1:0]     res_quad_q;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req      (arb_req),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .gnt_vld  (arb_vld),
    .next_ptr (arb_next)
  );

`ifdef CORDIC_SCHED_PRIO_EN
  // Channel 0 bypasses the rotation; the pointer only tracks channels 1..NCH-1.
  assign arb_req = {bus.req_valid[NCH-1:1], 1'b0};

  always_comb begin
    if (bus.req_valid[0]) begin
      gnt      = {{(NCH-1){1'b0}}, 1'b1};
      gnt_idx  = '0;
      gnt_vld  = 1'b1;
      ptr_next = ptr_q;
    end else begin
      gnt      = arb_gnt;
      gnt_idx  = arb_idx;
      gnt_vld  = arb_vld;
      ptr_next = (arb_next == '0) ? CHW'(1) : arb_next;
    end
  end
`else
  assign arb_req  = bus.req_valid;
  assign gnt      = arb_gnt;
  assign gnt_idx  = arb_idx;
  assign gnt_vld  = arb_vld;
  assign ptr_next = arb_next;
`endif

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < LAT; i++) pipe_any = pipe_any | pipe_q[i].vld;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                           state_d = RUN;
        else if (!pipe_any && !eng_load_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Ready is suppressed during reset so no handshake can slip through it.
  always_comb begin
    grant_ok  = (state_q == RUN) && en && !rst;
    req_ready = grant_ok ? gnt : '0;
    busy      = (state_q != IDLE) || pipe_any || eng_load_q;
  end

  // gnt only has bits on valid channels, so a grant is already a handshake.
  assign hs = grant_ok && gnt_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      eng_cx_q    <= '0;
      eng_cy_q    <= '0;
      eng_load_q  <= 1'b0;
      eng_chan_q  <= '0;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_chan_q  <= '0;
      res_theta_q <= '0;
      res_quad_q  <= '0;
    end else begin
      eng_load_q <= hs;
      if (hs) begin
        ptr_q      <= ptr_next;
        eng_cx_q   <= bus.req_cx[int'(gnt_idx)*DW +: DW];
        eng_cy_q   <= bus.req_cy[int'(gnt_idx)*DW +: DW];
        eng_chan_q <= gnt_idx;
      end
      // Stage 0 follows eng_load by one cycle, so the last stage lines up with engine output.
      pipe_q[0] <= tag_t'{vld: eng_load_q, chan: MAX_CHW'(eng_chan_q)};
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      res_valid_q <= pipe_q[LAT-1].vld;
      res_chan_q  <= CHW'(pipe_q[LAT-1].chan);
      res_theta_q <= bus.eng_theta;
      res_quad_q  <= bus.eng_quad;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.eng_cx    = eng_cx_q;
  assign bus.eng_cy    = eng_cy_q;
  assign bus.eng_load  = eng_load_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_chan  = res_chan_q;
  assign bus.res_theta = res_theta_q;
  assign bus.res_quad  = res_quad_q;

endmodule

// File: tb/tb_cordic_chan_sched.sv
// Bench for cordic_chan_sched: behavioural engine, arbitration reference model, result scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_cordic_chan_sched;
  import cordic_sched_pkg::*;

  localparam int NCH = 4;
  localparam int LAT = 10;
  localparam int DW  = 16;
  localparam int TW  = 17;
`ifdef CORDIC_SCHED_PRIO_EN
  localparam int PTR0 = 1;
`else
  localparam int PTR0 = 0;
`endif

  logic clk = 1'b0;
  logic rst, en, busy;
  always #5 clk = ~clk;

  cordic_chan_sched_if #(.NCH(NCH), .DW(DW), .TW(TW)) bus ();

  cordic_chan_sched #(.NCH(NCH), .LAT(LAT), .DW(DW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .busy(busy),
    .bus (bus)
  );

  typedef struct {
    int            chan;
    logic [TW-1:0] theta;
    logic [1:0]    quad;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine transfer function: arbitrary but bit-exact, so corruption of any input bit shows up.
  function automatic logic [TW-1:0] f_theta(input logic [DW-1:0] cx, input logic [DW-1:0] cy);
    return {cx ^ {cy[7:0], cy[15:8]}, cx[0] ^ cy[15]};
  endfunction

  function automatic logic [1:0] f_quad(input logic [DW-1:0] cx, input logic [DW-1:0] cy);
    return cx[15:14] ^ cy[1:0];
  endfunction

  // Winner for a given set of valids and rotation pointer.
  function automatic int pick(input logic [NCH-1:0] v, input int p);
`ifdef CORDIC_SCHED_PRIO_EN
    if (v[0]) return 0;
    for (int i = 0; i < NCH-1; i++) begin
      int k = 1 + ((p - 1 + i) % (NCH - 1));
      if (v[k]) return k;
    end
`else
    for (int i = 0; i < NCH; i++) begin
      int k = (p + i) % NCH;
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural LAT-cycle engine; drives junk when it has no result.
  logic [TW-1:0] eng_th_mem [64];
  logic [1:0]    eng_q_mem  [64];
  bit            eng_v      [64];

  initial begin
    bus.eng_theta = '0;
    bus.eng_quad  = '0;
  end

  always @(negedge clk) begin : engine
    if (bus.eng_load === 1'b1) begin
      eng_th_mem[(cyc + LAT) % 64] = f_theta(bus.eng_cx, bus.eng_cy);
      eng_q_mem[(cyc + LAT) % 64]  = f_quad(bus.eng_cx, bus.eng_cy);
      eng_v[(cyc + LAT) % 64]      = 1'b1;
    end
    if (eng_v[cyc % 64]) begin
      bus.eng_theta     = eng_th_mem[cyc % 64];
      bus.eng_quad      = eng_q_mem[cyc % 64];
      eng_v[cyc % 64]   = 1'b0;
    end else begin
      bus.eng_theta = TW'($urandom);
      bus.eng_quad  = 2'($urandom);
    end
  end

  // Reference model: grants only when enabled now and in the previous cycle, with no reset in either.
  int m_ptr   = PTR0;
  bit en_prev = 1'b0;
  bit rst_prev = 1'b1;

  always @(negedge clk) begin : model
    logic [NCH-1:0] exp_rdy;
    int             w;
    logic [DW-1:0]  cx, cy;
    w = -1;
    if (en_prev && !rst_prev && en && !rst) w = pick(bus.req_valid, m_ptr);
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (w >= 0) begin
      cx = bus.req_cx[w*DW +: DW];
      cy = bus.req_cy[w*DW +: DW];
      sb_q.push_back('{chan: w, theta: f_theta(cx, cy), quad: f_quad(cx, cy), due: cyc + LAT + 2});
`ifdef CORDIC_SCHED_PRIO_EN
      if (w != 0) m_ptr = (w == NCH-1) ? 1 : w + 1;
`else
      m_ptr = (w + 1) % NCH;
`endif
    end
    if (rst) begin
      m_ptr = PTR0;
      for (int i = sb_q.size() - 1; i >= 0; i--)
        if (sb_q[i].due > cyc) sb_q.delete(i);
    end
    en_prev  = en;
    rst_prev = rst;
  end

  // Monitor: every result must match the oldest outstanding issue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got res_valid=1 chan=%0d, required no result (cycle %0d)",
                 bus.res_chan, cyc);
      end else begin
        e = sb_q.pop_front();
        check("res_chan",    32'(bus.res_chan),  32'(e.chan));
        check("res_theta",   32'(bus.res_theta), 32'(e.theta));
        check("res_quad",    32'(bus.res_quad),  32'(e.quad));
        check("res_latency", 32'(cyc),           32'(e.due));
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_eng_load"},  32'(bus.eng_load),  0);
    check({tag, "_eng_cx"},    32'(bus.eng_cx),    0);
    check({tag, "_eng_cy"},    32'(bus.eng_cy),    0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_res_chan"},  32'(bus.res_chan),  0);
    check({tag, "_res_theta"}, 32'(bus.res_theta), 0);
    check({tag, "_res_quad"},  32'(bus.res_quad),  0);
    check({tag, "_busy"},      32'(busy),          0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    bus.req_cx = {$urandom, $urandom};
    bus.req_cy = {$urandom, $urandom};
  endtask

  task automatic wait_ready(input int ch, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready[ch] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, 32'(ok), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin : driver
    int  n;
    bit  found;
    rst           = 1'b1;
    en            = 1'b0;
    bus.req_valid = '0;
    bus.req_cx    = '0;
    bus.req_cy    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    next_cycle();
    rst = 1'b0;
    en  = 1'b1;

    // Single request on channel 2
    bus.req_cx[2*DW +: DW] = 16'h4000;
    bus.req_cy[2*DW +: DW] = 16'h0000;
    bus.req_valid          = 4'b0100;
    wait_ready(2, "t1_ready");
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_eng_load", 32'(bus.eng_load), 1);
    check("t1_eng_cx",   32'(bus.eng_cx),   32'h4000);
    idle(16);

    // All channels valid from a fresh pointer
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rand_data();
      bus.req_valid = 4'hF;
      next_cycle();
    end
    bus.req_valid = '0;
    idle(16);

    // Drop en after the third grant
    bus.req_valid = 4'hF;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      @(negedge clk);
      if (|bus.req_ready) n++;
      next_cycle();
      if (n >= 3) en = 1'b0;
    end
    bus.req_valid = '0;
    check("t3_grant_count", 32'(n), 3);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid === 1'b1 && sb_q.size() == 0) begin
        check("t3_busy_at_last_res", 32'(busy), 1);
        @(negedge clk);
        check("t3_busy_after_last_res", 32'(busy), 0);
        found = 1'b1;
        break;
      end
    end
    check("t3_last_result_seen", 32'(found), 1);
    idle(3);

    // Reset four cycles after an issue
    next_cycle();
    en            = 1'b1;
    bus.req_valid = 4'b0010;
    wait_ready(1, "t4_ready");
    next_cycle();
    bus.req_valid = '0;
    idle(3);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check_zero_outputs("t4_mid_reset");
    next_cycle();
    rst = 1'b0;
    idle(20);

    // en toggled while draining
    for (int i = 0; i < 4; i++) begin
      rand_data();
      bus.req_valid = 4'($urandom) | 4'b0001;
      next_cycle();
    end
    en = 1'b0;
    idle(2);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      bus.req_valid = 4'($urandom);
      next_cycle();
    end
    bus.req_valid = '0;
    idle(20);

`ifdef CORDIC_SCHED_PRIO_EN
    // Channel 0 priority, then rotation over 1..3
    for (int i = 0; i < 6; i++) begin
      rand_data();
      bus.req_valid = 4'b0011;
      next_cycle();
    end
    for (int i = 0; i < 7; i++) begin
      rand_data();
      bus.req_valid = 4'b1110;
      next_cycle();
    end
    bus.req_valid = '0;
    idle(16);
`endif

    // Randomised traffic with enable gaps and occasional resets
    for (int i = 0; i < 300; i++) begin
      rand_data();
      bus.req_valid = 4'($urandom);
      en            = ($urandom_range(0, 7) != 0);
      rst           = ($urandom_range(0, 99) == 0);
      next_cycle();
    end
    rst           = 1'b0;
    en            = 1'b0;
    bus.req_valid = '0;
    idle(30);
    check("sb_drained", 32'(sb_q.size()), 0);
    check("busy_final", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
